// File: rtl/midi_uart_rx_if.sv
// Byte-side bundle of the MIDI UART receiver.
// master drives received bytes and status, slave consumes them.
interface midi_uart_rx_if;
  logic [7:0] data;
  logic       dv;
  logic       frame_err;
  logic       busy;

  modport master (
    output data, dv, frame_err, busy
  );

  modport slave (
    input data, dv, frame_err, busy
  );
endinterface

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 serial receiver: synchronizer, 3-sample majority at mid-bit,
// false-start rejection, framing-error strobe and break wait.
module midi_uart_rx #(
  parameter int CLKS_PER_BIT = 1600,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic rx,
  midi_uart_rx_if.master bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int M  = CLKS_PER_BIT / 2;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_S0   = TW'(M - 1);
  localparam logic [TW-1:0] T_S1   = TW'(M);
  localparam logic [TW-1:0] T_DEC  = TW'(M + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic          rx_s;
  logic [TW-1:0] tc, tc_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic [7:0]    data_r, data_n;
  logic [1:0]    samp, samp_n;
  logic          dv, dv_n;
  logic          fe, fe_n;
  logic          maj;
  logic          dec;

  // Synchronizer runs on every clk, independent of ce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync[SYNC_STAGES-1];
  assign dec  = (tc == T_DEC);
  assign maj  = (samp[0] & samp[1]) |
                (samp[0] & rx_s) |
                (samp[1] & rx_s);

  always_comb begin
    state_n = state;
    tc_n    = tc;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = data_r;
    samp_n  = samp;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    if (state inside {START, DATA, STOP}) begin
      tc_n = (tc == T_LAST) ? '0 : tc + 1'b1;
      if (tc == T_S0) samp_n[0] = rx_s;
      if (tc == T_S1) samp_n[1] = rx_s;
    end
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          tc_n    = '0;
        end
      end
      START: begin
        if (dec && maj) begin
          state_n = IDLE;
          tc_n    = '0;
        end else if (tc == T_LAST) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (dec) sh_n = {maj, sh[7:1]};
        if (tc == T_LAST) begin
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        // Leave at mid stop bit so back-to-back frames are caught
        if (dec) begin
          tc_n = '0;
          if (maj) begin
            data_n  = sh;
            dv_n    = 1'b1;
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tc     <= '0;
      idx    <= '0;
      sh     <= '0;
      data_r <= '0;
      samp   <= '0;
      dv     <= 1'b0;
      fe     <= 1'b0;
    end else if (ce) begin
      state  <= state_n;
      tc     <= tc_n;
      idx    <= idx_n;
      sh     <= sh_n;
      data_r <= data_n;
      samp   <= samp_n;
      dv     <= dv_n;
      fe     <= fe_n;
    end
  end

  assign bus.data      = data_r;
  assign bus.dv        = dv;
  assign bus.frame_err = fe;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Bench for midi_uart_rx: table of frames, corner sequences,
// random frames checked against an expected byte/event queue.
module tb_midi_uart_rx;

  localparam int CPB = 16;
  localparam int M   = CPB / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  logic rx  = 1'b1;

  midi_uart_rx_if bus ();

  midi_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .rx (rx),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         fe;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    bit         stop;
    int         gbit;
    int         gpos;
    int         gap;
    logic [7:0] exp_d;
  } vec_t;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  alt_ce = 1'b0;
  bit  dv_hold_seen = 1'b0;
  bit  busy_all;
  ev_t exp_q[$];
  ev_t obs_q[$];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Consumer view: an event is what a ce-qualified sampler sees
  always @(negedge clk) begin
    if (!rst) begin
      if (ce && (bus.dv || bus.frame_err)) begin
        ev_t e;
        check("dv_fe_excl", {31'b0, bus.dv & bus.frame_err}, 32'd0);
        e.fe = bus.frame_err;
        e.d  = bus.data;
        obs_q.push_back(e);
      end
      if (!ce && bus.dv) dv_hold_seen = 1'b1;
    end
  end

  task automatic step(input logic v);
    rx = v;
    ce = 1'b1;
    @(posedge clk);
    #1;
    if (alt_ce) begin
      ce = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int nbits);
    for (int i = 0; i < nbits * CPB; i++) step(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop,
                            input int gbit, input int gpos);
    logic [9:0] fr;
    logic v;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int p = 0; p < CPB; p++) begin
        v = fr[k];
        if (k == gbit + 1 && p == gpos) v = ~v;
        step(v);
        if (k >= 1 && k <= 8 && p == M) busy_all &= bus.busy;
      end
    end
  endtask

  task automatic expect_ev(input bit fe, input logic [7:0] d);
    ev_t e;
    e.fe = fe;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  task automatic drain_compare(input string name);
    int n;
    check({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_fe"}, {31'b0, obs_q[i].fe}, {31'b0, exp_q[i].fe});
      check({name, "_data"}, {24'b0, obs_q[i].d}, {24'b0, exp_q[i].d});
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  vec_t tv[9];

  initial begin
    tv[0] = '{8'h90, 1'b1, -1, 0,     2, 8'h90};
    tv[1] = '{8'h90, 1'b1, -1, 0,     0, 8'h90};
    tv[2] = '{8'h3C, 1'b1, -1, 0,     0, 8'h3C};
    tv[3] = '{8'h64, 1'b1, -1, 0,     2, 8'h64};
    tv[4] = '{8'hC3, 1'b1, 3,  M + 1, 2, 8'hC3};
    tv[5] = '{8'h00, 1'b1, -1, 0,     1, 8'h00};
    tv[6] = '{8'hFF, 1'b1, 6,  M,     1, 8'hFF};
    tv[7] = '{8'h01, 1'b1, 0,  M + 2, 1, 8'h01};
    tv[8] = '{8'h80, 1'b1, 7,  M + 1, 1, 8'h80};

    rst = 1'b1;
    ce  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {24'b0, bus.data}, 32'h00);
    check("rst_dv", {31'b0, bus.dv}, 32'd0);
    check("rst_fe", {31'b0, bus.frame_err}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 9; i++) begin
      busy_all = 1'b1;
      send_frame(tv[i].b, tv[i].stop, tv[i].gbit, tv[i].gpos);
      expect_ev(1'b0, tv[i].exp_d);
      check("busy_frame", {31'b0, busy_all}, 32'd1);
      if (tv[i].gap > 0) begin
        idle(tv[i].gap);
        check("busy_idle", {31'b0, bus.busy}, 32'd0);
        drain_compare("vec");
      end
    end

    // short low pulse must be discarded
    for (int i = 0; i < 4; i++) step(1'b0);
    for (int i = 0; i < 2 * CPB; i++) step(1'b1);
    check("fs_busy", {31'b0, bus.busy}, 32'd0);
    drain_compare("false_start");
    send_frame(8'h55, 1'b1, -1, 0);
    expect_ev(1'b0, 8'h55);
    idle(2);
    drain_compare("after_fs");

    // bad stop bit followed by a held-low line
    send_frame(8'hA5, 1'b0, -1, 0);
    for (int i = 0; i < 40; i++) step(1'b0);
    check("break_busy", {31'b0, bus.busy}, 32'd1);
    expect_ev(1'b1, 8'h55);
    idle(2);
    drain_compare("frame_err");
    check("fe_data_kept", {24'b0, bus.data}, 32'h55);
    send_frame(8'h12, 1'b1, -1, 0);
    expect_ev(1'b0, 8'h12);
    idle(2);
    drain_compare("after_fe");

    // random frames with random single-cycle noise inside data bits
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      int gb;
      int gp;
      b  = 8'($urandom);
      gb = ($urandom_range(1, 0) == 1) ? int'($urandom_range(7, 0)) : -1;
      gp = int'($urandom_range(CPB - 1, 0));
      send_frame(b, 1'b1, gb, gp);
      expect_ev(1'b0, b);
      idle(int'($urandom_range(2, 0)));
    end
    idle(2);
    drain_compare("random");

    // half-rate ce, then reset in the middle of the next byte
    alt_ce = 1'b1;
    dv_hold_seen = 1'b0;
    send_frame(8'h7F, 1'b1, -1, 0);
    expect_ev(1'b0, 8'h7F);
    idle(2);
    drain_compare("ce_alt");
    check("dv_hold", {31'b0, dv_hold_seen}, 32'd1);
    check("ce_data", {24'b0, bus.data}, 32'h7F);

    begin
      logic [9:0] fr;
      fr = {1'b1, 8'hF0, 1'b0};
      for (int k = 0; k < 10; k++) begin
        for (int p = 0; p < CPB; p++) begin
          step(fr[k]);
          if (k == 5 && p == 5) begin
            #2 rst = 1'b1;
            #1;
            check("mid_rst_data", {24'b0, bus.data}, 32'h00);
            check("mid_rst_dv", {31'b0, bus.dv}, 32'd0);
            check("mid_rst_fe", {31'b0, bus.frame_err}, 32'd0);
            check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
          end
        end
      end
    end
    idle(2);
    drain_compare("after_rst");
    check("after_rst_data", {24'b0, bus.data}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
